// File: rtl/pwm_cfg_arbiter.sv
// pwm_cfg_arbiter
// Round-robin Wishbone master sharing the pwm_timer register port between
// NUM_REQ local requesters. Each grant runs one single-word classic Wishbone
// cycle, returns read data or an ack-timeout error, and is followed by one
// idle (GAP) cycle so a registered ack from the slave is never credited to
// the next transaction.

module pwm_cfg_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [NUM_REQ-1:0]      i_req,
   input  logic [NUM_REQ-1:0]      i_we,
   input  logic [16*NUM_REQ-1:0]   i_adr,
   input  logic [16*NUM_REQ-1:0]   i_wdata,
   output logic [NUM_REQ-1:0]      o_gnt,
   output logic [NUM_REQ-1:0]      o_done,
   output logic [15:0]             o_rdata,
   output logic                    o_err,
   output logic                    o_busy,
   output logic                    o_wb_cyc,
   output logic                    o_wb_stb,
   output logic                    o_wb_we,
   output logic [15:0]             o_wb_adr,
   output logic [15:0]             o_wb_data,
   input  logic                    i_wb_ack,
   input  logic [15:0]             i_wb_data
);

   localparam int                 IDX_W       = $clog2(NUM_REQ);
   localparam int                 CNT_W       = 8;
   localparam logic [CNT_W-1:0]   TIMEOUT_CNT = CNT_W'(TIMEOUT);
   localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     ptr, ptr_nxt;
   logic [IDX_W-1:0]     win_q, win_q_nxt;
   logic [IDX_W-1:0]     win;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic                 any_req;
   logic                 can_grant;
   logic                 timed_out;

   logic [NUM_REQ-1:0]   gnt_nxt, done_nxt;
   logic [15:0]          rdata_nxt, wb_adr_nxt, wb_data_nxt;
   logic                 err_nxt, busy_nxt, cyc_nxt, stb_nxt, we_nxt;

   assign any_req   = |i_req;
   // GAP doubles as an arbitration slot so back-to-back grants land every 3 cycles.
   assign can_grant = any_req && ((state == ST_IDLE) || (state == ST_GAP));
   assign timed_out = (cnt == TIMEOUT_CNT);

   // Round-robin scan starting at ptr; the first asserted request wins.
   always_comb begin
      logic             found;
      int               idx;
      logic [IDX_W-1:0] idx_l;
      // NOTE: every variable gets a value before any branch so no latch is inferred.
      win   = ptr;
      found = 1'b0;
      idx   = 0;
      idx_l = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_l = IDX_W'(idx);
         if (!found && i_req[idx_l]) begin
            win   = idx_l;
            found = 1'b1;
         end
      end
   end

   // State register plus all registered outputs and datapath state.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         win_q     <= '0;
         cnt       <= '0;
         o_gnt     <= '0;
         o_done    <= '0;
         o_rdata   <= '0;
         o_err     <= 1'b0;
         o_busy    <= 1'b0;
         o_wb_cyc  <= 1'b0;
         o_wb_stb  <= 1'b0;
         o_wb_we   <= 1'b0;
         o_wb_adr  <= '0;
         o_wb_data <= '0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         win_q     <= win_q_nxt;
         cnt       <= cnt_nxt;
         o_gnt     <= gnt_nxt;
         o_done    <= done_nxt;
         o_rdata   <= rdata_nxt;
         o_err     <= err_nxt;
         o_busy    <= busy_nxt;
         o_wb_cyc  <= cyc_nxt;
         o_wb_stb  <= stb_nxt;
         o_wb_we   <= we_nxt;
         o_wb_adr  <= wb_adr_nxt;
         o_wb_data <= wb_data_nxt;
      end
   end

   // Next-state logic; ack wins over a simultaneous timeout, and ack is ignored outside BUS.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (any_req) state_nxt = ST_BUS;
         ST_BUS:  if (i_wb_ack || timed_out) state_nxt = ST_GAP;
         ST_GAP:  state_nxt = any_req ? ST_BUS : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Next values for outputs, pointer, winner and timeout counter.
   always_comb begin
      gnt_nxt     = '0;
      done_nxt    = '0;
      err_nxt     = 1'b0;
      rdata_nxt   = o_rdata;
      cyc_nxt     = o_wb_cyc;
      stb_nxt     = o_wb_stb;
      we_nxt      = o_wb_we;
      wb_adr_nxt  = o_wb_adr;
      wb_data_nxt = o_wb_data;
      ptr_nxt     = ptr;
      win_q_nxt   = win_q;
      cnt_nxt     = cnt;
      busy_nxt    = (state_nxt != ST_IDLE);

      if (can_grant) begin
         gnt_nxt[win] = 1'b1;
         win_q_nxt    = win;
         ptr_nxt      = (win == LAST_IDX) ? '0 : win + 1'b1;
         cyc_nxt      = 1'b1;
         stb_nxt      = 1'b1;
         we_nxt       = i_we[win];
         wb_adr_nxt   = i_adr[16*win +: 16];
         wb_data_nxt  = i_wdata[16*win +: 16];
         cnt_nxt      = '0;
      end else if (state == ST_BUS) begin
         if (i_wb_ack) begin
            cyc_nxt         = 1'b0;
            stb_nxt         = 1'b0;
            rdata_nxt       = i_wb_data;
            done_nxt[win_q] = 1'b1;
            err_nxt         = 1'b0;
         end else if (timed_out) begin
            cyc_nxt         = 1'b0;
            stb_nxt         = 1'b0;
            rdata_nxt       = '0;
            done_nxt[win_q] = 1'b1;
            err_nxt         = 1'b1;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Directed bench for pwm_cfg_arbiter against a small pwm_timer-style
// register slave with a registered ack and an optional sticky-ack extension.

module tb_pwm_cfg_arbiter;

   localparam int NR = 4;
   localparam int TO = 15;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic [NR-1:0] req, we;
   logic [16*NR-1:0] adr, wdata;
   logic [NR-1:0] gnt, done;
   logic [15:0]   rdata;
   logic          err, busy;
   logic          wb_cyc, wb_stb, wb_we;
   logic [15:0]   wb_adr, wb_data;
   logic          ack;
   logic [15:0]   s_rdata;

   int checks   = 0;
   int failures = 0;

   // Slave model controls.
   logic          slave_en;
   int            sticky;
   int            hold;
   logic [15:0]   mem [16];

   always #5 i_clk = ~i_clk;

   pwm_cfg_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_req     (req),
      .i_we      (we),
      .i_adr     (adr),
      .i_wdata   (wdata),
      .o_gnt     (gnt),
      .o_done    (done),
      .o_rdata   (rdata),
      .o_err     (err),
      .o_busy    (busy),
      .o_wb_cyc  (wb_cyc),
      .o_wb_stb  (wb_stb),
      .o_wb_we   (wb_we),
      .o_wb_adr  (wb_adr),
      .o_wb_data (wb_data),
      .i_wb_ack  (ack),
      .i_wb_data (s_rdata)
   );

   // Register slave: ack and read data registered from cyc&stb; ack can linger 'sticky' cycles.
   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ack     <= 1'b0;
         hold    <= 0;
         s_rdata <= 16'h0000;
         for (int i = 0; i < 16; i++) mem[i] <= 16'h1000 + 16'(i);
      end else begin
         if (wb_cyc && wb_stb) begin
            hold    <= sticky;
            s_rdata <= mem[wb_adr[3:0]];
            if (slave_en && wb_we) mem[wb_adr[3:0]] <= wb_data;
         end else if (hold > 0) begin
            hold <= hold - 1;
         end
         ack <= slave_en && ((wb_cyc && wb_stb) || (hold > 0));
      end
   end

   task automatic step();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt"},   32'(gnt),     32'h0);
      check({tag, "_done"},  32'(done),    32'h0);
      check({tag, "_rdata"}, 32'(rdata),   32'h0);
      check({tag, "_err"},   32'(err),     32'h0);
      check({tag, "_busy"},  32'(busy),    32'h0);
      check({tag, "_cyc"},   32'(wb_cyc),  32'h0);
      check({tag, "_stb"},   32'(wb_stb),  32'h0);
      check({tag, "_we"},    32'(wb_we),   32'h0);
      check({tag, "_adr"},   32'(wb_adr),  32'h0);
      check({tag, "_data"},  32'(wb_data), 32'h0);
   endtask

   initial begin
      i_rst_n  = 1'b0;
      req      = '0;
      we       = '0;
      adr      = '0;
      wdata    = '0;
      slave_en = 1'b1;
      sticky   = 0;

      // Reset state.
      step();
      step();
      check_all_zero("reset");
      i_rst_n = 1'b1;
      step();
      check("idle_busy", 32'(busy), 32'h0);

      // Single write: req0 writes 0x07D0 to 0x0002.
      req[0] = 1'b1; we[0] = 1'b1; adr[15:0] = 16'h0002; wdata[15:0] = 16'h07D0;
      step();
      check("wr_gnt",  32'(gnt),     32'h1);
      check("wr_cyc",  32'(wb_cyc),  32'h1);
      check("wr_stb",  32'(wb_stb),  32'h1);
      check("wr_we",   32'(wb_we),   32'h1);
      check("wr_adr",  32'(wb_adr),  32'h0002);
      check("wr_data", 32'(wb_data), 32'h07D0);
      check("wr_busy", 32'(busy),    32'h1);
      req[0] = 1'b0;
      step();
      check("wr_gnt_pulse", 32'(gnt),    32'h0);
      check("wr_no_done1",  32'(done),   32'h0);
      check("wr_cyc_hold",  32'(wb_cyc), 32'h1);
      step();
      check("wr_done",     32'(done),   32'h1);
      check("wr_err",      32'(err),    32'h0);
      check("wr_cyc_drop", 32'(wb_cyc), 32'h0);
      check("wr_stb_drop", 32'(wb_stb), 32'h0);
      check("wr_gap_busy", 32'(busy),   32'h1);
      step();
      check("wr_idle_busy", 32'(busy), 32'h0);
      check("wr_done_once", 32'(done), 32'h0);

      // Readback through req3 (ptr=1 scans 1,2,3 -> 3; ptr becomes 0).
      req[3] = 1'b1; we[3] = 1'b0; adr[63:48] = 16'h0002;
      step();
      check("rb_gnt", 32'(gnt),    32'h8);
      check("rb_we",  32'(wb_we),  32'h0);
      check("rb_adr", 32'(wb_adr), 32'h0002);
      req[3] = 1'b0;
      step();
      step();
      check("rb_done",  32'(done),  32'h8);
      check("rb_rdata", 32'(rdata), 32'h07D0);
      check("rb_err",   32'(err),   32'h0);
      step();

      // Round-robin: all four requesters, four reads each, one grant per 3 cycles.
      for (int i = 0; i < NR; i++) begin
         we[i] = 1'b0;
         adr[16*i +: 16] = 16'h0004 + 16'(i);
      end
      req = 4'hF;
      for (int k = 0; k < 16; k++) begin
         step();
         check($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(1) << (k % 4));
         if (k >= 12) req[k % 4] = 1'b0;
         step();
         check($sformatf("rr_gnt_off%0d", k), 32'(gnt), 32'h0);
         step();
         check($sformatf("rr_done%0d", k),  32'(done),  32'(1) << (k % 4));
         check($sformatf("rr_rdata%0d", k), 32'(rdata), 32'h1004 + 32'(k % 4));
      end
      step();
      check("rr_end_busy", 32'(busy), 32'h0);
      check("rr_end_gnt",  32'(gnt),  32'h0);

      // Sticky ack: ack lingers through GAP and IDLE; no spurious done.
      sticky = 2;
      req[2] = 1'b1; adr[47:32] = 16'h0005;
      step();
      check("st_gnt", 32'(gnt), 32'h4);
      req[2] = 1'b0;
      step();
      step();
      check("st_done",  32'(done),  32'h4);
      check("st_rdata", 32'(rdata), 32'h1005);
      step();
      check("st_gap_no_done", 32'(done), 32'h0);
      step();
      check("st_idle_no_done", 32'(done), 32'h0);
      req[1] = 1'b1; we[1] = 1'b0; adr[31:16] = 16'h0006;
      step();
      check("st_gnt2",     32'(gnt),  32'h2);
      check("st_no_done2", 32'(done), 32'h0);
      req[1] = 1'b0;
      step();
      check("st_no_early_done", 32'(done), 32'h0);
      step();
      check("st_done2",  32'(done),  32'h2);
      check("st_rdata2", 32'(rdata), 32'h1006);
      sticky   = 0;
      slave_en = 1'b0;
      step();

      // Timeout: ack tied low; ptr=2 so req3 beats req0.
      req[0] = 1'b1; we[0] = 1'b1; adr[15:0]  = 16'h0007; wdata[15:0] = 16'h1234;
      req[3] = 1'b1; we[3] = 1'b0; adr[63:48] = 16'h0008;
      step();
      check("to_gnt", 32'(gnt), 32'h8);
      req[3] = 1'b0;
      for (int j = 1; j <= TO; j++) begin
         step();
         check($sformatf("to_wait%0d", j), 32'(done), 32'h0);
      end
      check("to_cyc_still", 32'(wb_cyc), 32'h1);
      step();
      check("to_done",  32'(done),   32'h8);
      check("to_err",   32'(err),    32'h1);
      check("to_rdata", 32'(rdata),  32'h0);
      check("to_cyc",   32'(wb_cyc), 32'h0);
      step();
      check("to_next_gnt",  32'(gnt),     32'h1);
      check("to_next_we",   32'(wb_we),   32'h1);
      check("to_next_adr",  32'(wb_adr),  32'h0007);
      check("to_next_data", 32'(wb_data), 32'h1234);
      req[0] = 1'b0;

      // Reset mid-BUS: outputs clear asynchronously, no done afterwards.
      step();
      check("rst_pre_cyc", 32'(wb_cyc), 32'h1);
      #2 i_rst_n = 1'b0;
      #1 check_all_zero("rst_async");
      step();
      check("rst_no_done", 32'(done),   32'h0);
      check("rst_cyc_low", 32'(wb_cyc), 32'h0);
      i_rst_n  = 1'b1;
      slave_en = 1'b1;

      // After reset ptr=0: req0 wins over req2. Operands change after grant.
      req[0] = 1'b1; we[0] = 1'b1; adr[15:0]  = 16'h0009; wdata[15:0] = 16'hBEEF;
      req[2] = 1'b1; we[2] = 1'b0; adr[47:32] = 16'h0009;
      step();
      check("pr_gnt", 32'(gnt), 32'h1);
      req[0] = 1'b0; adr[15:0] = 16'hFFFF; wdata[15:0] = 16'h0000;
      step();
      check("op_adr_kept",  32'(wb_adr),  32'h0009);
      check("op_data_kept", 32'(wb_data), 32'hBEEF);
      check("op_cyc",       32'(wb_cyc),  32'h1);
      step();
      check("op_done", 32'(done), 32'h1);
      check("op_err",  32'(err),  32'h0);
      step();
      check("op_gnt2", 32'(gnt),    32'h4);
      check("op_adr2", 32'(wb_adr), 32'h0009);
      check("op_we2",  32'(wb_we),  32'h0);
      req[2] = 1'b0;
      step();
      step();
      check("op_done2",  32'(done),  32'h4);
      check("op_rdata2", 32'(rdata), 32'hBEEF);
      step();
      check("op_idle_busy", 32'(busy), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
